// File: rtl/ghr_ctrl.sv
// Global history register controller: speculative/committed history plus a checkpoint FIFO for recovery.
// Optional saturating statistics counters are built only when GHR_CTRL_STATS_EN is defined.
module ghr_ctrl #(
    parameter int GHR_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    input  logic                 res_valid,
    input  logic                 res_taken,
    input  logic                 res_mispredict,
    input  logic                 flush,
    output logic [GHR_WIDTH-1:0] ghr,
    output logic [GHR_WIDTH-1:0] ex_ghr,
    output logic                 full,
    output logic                 empty,
    output logic [31:0]          stat_pred_cnt,
    output logic [31:0]          stat_mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [GHR_WIDTH-1:0] spec_q, spec_d;
    logic [GHR_WIDTH-1:0] arch_q, arch_d;
    logic [GHR_WIDTH-1:0] fifo_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GHR_WIDTH-1:0] head;
    logic [GHR_WIDTH-1:0] recover_hist;
    logic                 do_mispred, do_resolve, do_push;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    assign ghr    = spec_q;
    assign ex_ghr = empty ? arch_q : head;

    // Event qualification: a mispredict kills everything younger, a flush kills any same-cycle predict.
    assign do_mispred   = res_valid & res_mispredict & ~empty;
    assign do_resolve   = res_valid & ~res_mispredict & ~empty;
    assign do_push      = pred_valid & ~full & ~do_mispred & ~flush;
    assign recover_hist = {head[GHR_WIDTH-2:0], res_taken};

    always_comb begin
        spec_d   = spec_q;
        arch_d   = arch_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_mispred) begin
            spec_d   = recover_hist;
            arch_d   = recover_hist;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_resolve) begin
                arch_d   = {arch_q[GHR_WIDTH-2:0], res_taken};
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (flush) begin
                spec_d   = arch_d;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (do_push) begin
                    spec_d   = {spec_q[GHR_WIDTH-2:0], pred_taken};
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                cnt_d = cnt_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_resolve};
            end
        end
    end

    // NOTE: non-blocking assignments in every clocked block so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_q   <= '0;
            arch_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            spec_q   <= spec_d;
            arch_q   <= arch_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: snapshot storage is not reset; a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_q[wr_ptr_q] <= spec_q;
        end
    end

`ifdef GHR_CTRL_STATS_EN
    logic [31:0] pred_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (do_push && pred_cnt_q != 32'hFFFF_FFFF) begin
                pred_cnt_q <= pred_cnt_q + 32'd1;
            end
            if (do_mispred && mispred_cnt_q != 32'hFFFF_FFFF) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pred_cnt    = pred_cnt_q;
    assign stat_mispred_cnt = mispred_cnt_q;
`else
    assign stat_pred_cnt    = '0;
    assign stat_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_ghr_ctrl.sv
// Directed self-checking bench for ghr_ctrl; expected histories are hand-computed per step.
module tb_ghr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pred_valid = 1'b0, pred_taken = 1'b0;
    logic       res_valid = 1'b0, res_taken = 1'b0, res_mispredict = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] ghr, ex_ghr;
    logic       full, empty;
    logic [31:0] stat_pred_cnt, stat_mispred_cnt;

    int total = 0;
    int bad   = 0;

    ghr_ctrl #(.GHR_WIDTH(8), .DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .flush            (flush),
        .ghr              (ghr),
        .ex_ghr           (ex_ghr),
        .full             (full),
        .empty            (empty),
        .stat_pred_cnt    (stat_pred_cnt),
        .stat_mispred_cnt (stat_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic pv, input logic pt, input logic rv, input logic rt,
                       input logic rm, input logic fl);
        pred_valid = pv; pred_taken = pt;
        res_valid = rv; res_taken = rt; res_mispredict = rm;
        flush = fl;
        @(posedge clk);
        #1;
        pred_valid = 1'b0; pred_taken = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_ghr", ghr, 8'h00);
        check("rst_ex_ghr", ex_ghr, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_stat_pred", stat_pred_cnt, 0);
        check("rst_stat_mis", stat_mispred_cnt, 0);
        do_reset();

        // Predict T, N, T: pushes 00, 01, 02.
        cyc(1, 1, 0, 0, 0, 0);
        check("p1_ghr", ghr, 8'h01);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check("p3_ghr", ghr, 8'h05);
        check("p3_ex_ghr", ex_ghr, 8'h00);
        check("p3_empty", empty, 0);
        check("p3_full", full, 0);

        // Correct resolve taken: arch 01, head now 01.
        cyc(0, 0, 1, 1, 0, 0);
        check("res_ex_ghr", ex_ghr, 8'h01);
        check("res_ghr", ghr, 8'h05);

        // Mispredict on head 01 with res_taken=0 plus a younger predict.
        cyc(1, 1, 1, 0, 1, 0);
        check("mis1_ghr", ghr, 8'h02);
        check("mis1_arch", ex_ghr, 8'h02);
        check("mis1_empty", empty, 1);

        // Exact case: ghr 05, FIFO 00/01/02, mispredict taken=0 with predict.
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0);
        check("mis2_ghr", ghr, 8'h00);
        check("mis2_arch", ex_ghr, 8'h00);
        check("mis2_empty", empty, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("mis2_nopush", empty, 1);

        // Fill: pushes 00, 01, 03, 07; ghr 0F.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
        check("fill_ghr", ghr, 8'h0F);
        check("fill_full", full, 1);
        cyc(1, 1, 0, 0, 0, 0);
        check("drop_ghr", ghr, 8'h0F);
        check("drop_full", full, 1);
        // Resolve + predict while full: predict dropped, head 00 popped.
        cyc(1, 1, 1, 0, 0, 0);
        check("rp_ghr", ghr, 8'h0F);
        check("rp_ex_ghr", ex_ghr, 8'h01);
        cyc(0, 0, 1, 1, 0, 0);
        check("drain1_ex", ex_ghr, 8'h03);
        cyc(0, 0, 1, 1, 0, 0);
        check("drain2_ex", ex_ghr, 8'h07);
        check("drain2_empty", empty, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("drain3_empty", empty, 1);
        // arch: 00 -> 00 -> 01 -> 03 -> 07
        check("drain3_arch", ex_ghr, 8'h07);

        // Flush with arch 03 and 3 entries in flight.
        do_reset();
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("fl_arch", ex_ghr, 8'h03);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        check("fl_pre_ghr", ghr, 8'h18);
        check("fl_pre_ex", ex_ghr, 8'h03);
        cyc(1, 1, 0, 0, 0, 1);
        check("fl_ghr", ghr, 8'h03);
        check("fl_empty", empty, 1);
        cyc(0, 0, 1, 1, 1, 0);
        check("idle_res_ghr", ghr, 8'h03);
        check("idle_res_ex", ex_ghr, 8'h03);
        check("idle_res_empty", empty, 1);

        // Flush with same-cycle correct resolve: ghr takes updated arch.
        cyc(1, 1, 0, 0, 0, 0);
        check("frs_pre_ghr", ghr, 8'h07);
        cyc(0, 0, 1, 0, 0, 1);
        check("frs_ghr", ghr, 8'h06);
        check("frs_empty", empty, 1);

        // Mispredict beats flush.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 1);
        check("mvf_ghr", ghr, 8'h0C);
        check("mvf_arch", ex_ghr, 8'h0C);

        // Stats: 5 accepted predicts, 2 mispredicts.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
`ifdef GHR_CTRL_STATS_EN
        check("stat_pred", stat_pred_cnt, 5);
        check("stat_mis", stat_mispred_cnt, 2);
`else
        check("stat_pred_off", stat_pred_cnt, 0);
        check("stat_mis_off", stat_mispred_cnt, 0);
`endif

        // Asynchronous reset between clock edges.
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        check("ar_pre_empty", empty, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ghr", ghr, 8'h00);
        check("ar_ex_ghr", ex_ghr, 8'h00);
        check("ar_empty", empty, 1);
        check("ar_full", full, 0);
        check("ar_stat_pred", stat_pred_cnt, 0);
        check("ar_stat_mis", stat_mispred_cnt, 0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
